booth_restoring_divider: RTL
============================

Name: booth_restoring_divider

Overview:
- Sequential restoring divider; the inverse of the Booth multiplier datapath. Reuses the subtract-and-test step: one quotient bit per clock.
- Takes WIDTH-bit dividend and divisor, signed or unsigned. Returns quotient, remainder and status flags.
- Uses a start/busy/done handshake so the P2 top-level controller can sequence multiply and divide operations on shared operand buses.

Parameters:
- WIDTH, 16, operand / quotient / remainder width in bits (≥4)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- Signed_Mode  input  1  1 = two's-complement operands, 0 = unsigned
- Dividend  input  WIDTH  numerator, captured when start accepted
- Divisor  input  WIDTH  denominator, captured when start accepted
- Quotient  output  WIDTH  result, registered
- Remainder  output  WIDTH  result, registered
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results are valid
- DIV_ZERO  output  1  divisor was 0 on the last operation
- OVF  output  1  signed most-negative / −1 on the last operation

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset (next edge with rst=1, in any state including mid-operation):
  - State goes to IDLE.
  - Quotient, Remainder, busy, done, DIV_ZERO and OVF all become 0.
  - Any in-flight result is discarded.
- States: IDLE, ITER, SIGNFIX, DONE.
- IDLE:
  - busy=0.
  - start=1 at edge E0: capture magnitudes, sign flags (meaningful only when Signed_Mode=1) and Signed_Mode.
  - Load partial remainder with 0 and bit counter with WIDTH−1. busy=1 from E0.
  - Divisor==0: go to DONE instead of ITER.
  - Otherwise go to ITER.
- ITER, one edge per bit, WIDTH edges (E0+1 … E0+WIDTH):
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial = partial remainder − divisor magnitude, computed WIDTH+1 bits wide.
  - Trial non-negative: keep trial and shift in quotient bit 1. Otherwise restore and shift in 0.
  - When the counter reaches 0, go to SIGNFIX.
- SIGNFIX, edge E0+WIDTH+1:
  - Quotient negated if signs differ.
  - Remainder negated if dividend was negative (signed mode only).
  - Result truncates toward zero; remainder takes the dividend's sign.
  - Load the output registers and go to DONE.
- DONE:
  - done=1 for exactly one cycle: E0+WIDTH+2 when SIGNFIX ran, E0+1 on the divide-by-zero path.
  - busy=0 together with done.
  - Return to IDLE next edge.
  - start during DONE is ignored; it must be re-presented in IDLE.
- Latency: done visible WIDTH+2 cycles after the start edge (18 for WIDTH=16). Divide-by-zero: 1 cycle.
- Divide by zero:
  - Quotient = all ones. Remainder = Dividend as captured.
  - DIV_ZERO=1, OVF=0.
- Overflow (signed, Dividend = 100…0, Divisor = all ones):
  - Quotient = 100…0 (wraps). Remainder = 0.
  - OVF=1, DIV_ZERO=0.
- Flags:
  - DIV_ZERO and OVF are updated at the same edge as Quotient/Remainder.
  - They are held until the next result load, and cleared when a new start is accepted.
- Output holding:
  - Quotient/Remainder hold their last values while busy and in IDLE.
  - They change only at SIGNFIX, at the divide-by-zero DONE entry, or on reset.
- Input stability: Dividend, Divisor and Signed_Mode changing after the start edge have no effect.
- start while busy: ignored, no queueing.
- Unsigned mode: no magnitude conversion or sign fix. The most-negative/−1 case is an ordinary division (no OVF).

Test Plan:
- Signed 100 / 7 → done at cycle 18, Quotient=14, Remainder=2, flags 0. Signed −100 / 7 → Quotient=−14 (0xFFF2), Remainder=−2 (0xFFFE).
- Signed 7 / −100 → Quotient=0, Remainder=7. Unsigned 0xFFFF / 0x0010 → Quotient=0x0FFF, Remainder=0x000F.
- Signed 0x8000 / 0xFFFF → Quotient=0x8000, Remainder=0, OVF=1. Same operands unsigned → Quotient=0, Remainder=0x8000, OVF=0.
- Divisor=0, Dividend=0x1234 → done one cycle after start, Quotient=0xFFFF, Remainder=0x1234, DIV_ZERO=1. Next valid start clears DIV_ZERO.
- rst=1 at ITER cycle 8 → next edge all outputs 0, busy=0. A new start of 50/5 then yields Quotient=10, Remainder=0 with normal latency.
- start held high continuously with changing operands → only IDLE-sampled starts accepted (one op per 19 cycles). Mid-op operand changes do not alter results; done pulses exactly once per op.

Source files
------------

// File: rtl/booth_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock on operand magnitudes,
// followed by a sign-fix step. Start/busy/done handshake for a shared-bus controller.
module booth_restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             DIV_ZERO,
    output logic             OVF
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ITER    = 2'd1;
    localparam logic [1:0] ST_SIGNFIX = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_prem;
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_ovf_pend;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic             r_ovf;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_ovf_case;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_trial_ok;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_dvd_neg  = Signed_Mode & Dividend[WIDTH-1];
    assign w_dvs_neg  = Signed_Mode & Divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -Dividend : Dividend;
    assign w_dvs_mag  = w_dvs_neg ? -Divisor  : Divisor;
    assign w_ovf_case = Signed_Mode && (Dividend == MOST_NEG) && (Divisor == {WIDTH{1'b1}});

    // The shifted partial remainder needs WIDTH+1 bits; the borrow out of the
    // trial subtraction (bit WIDTH) is the restore decision.
    assign w_shift    = {r_prem, r_dq[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dvs};
    assign w_trial_ok = ~w_trial[WIDTH];

    assign w_q_fix = r_neg_q ? -r_dq   : r_dq;
    assign w_r_fix = r_neg_r ? -r_prem : r_prem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prem      <= '0;
            r_dq        <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_ovf_pend  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_prem     <= '0;
                        r_dq       <= w_dvd_mag;
                        r_dvs      <= w_dvs_mag;
                        r_cnt      <= CW'(WIDTH - 1);
                        r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r    <= w_dvd_neg;
                        r_ovf_pend <= w_ovf_case;
                        r_ovf      <= 1'b0;
                        if (Divisor == '0) begin
                            // Divide-by-zero bypasses the iteration entirely.
                            r_quotient  <= '1;
                            r_remainder <= Dividend;
                            r_div_zero  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_div_zero <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    if (w_trial_ok) begin
                        r_prem <= w_trial[WIDTH-1:0];
                        r_dq   <= {r_dq[WIDTH-2:0], 1'b1};
                    end else begin
                        r_prem <= w_shift[WIDTH-1:0];
                        r_dq   <= {r_dq[WIDTH-2:0], 1'b0};
                    end
                    if (r_cnt == '0) begin
                        r_state <= ST_SIGNFIX;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_SIGNFIX: begin
                    r_quotient  <= w_q_fix;
                    r_remainder <= w_r_fix;
                    r_ovf       <= r_ovf_pend;
                    r_div_zero  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Quotient  = r_quotient;
    assign Remainder = r_remainder;
    assign busy      = r_busy;
    assign done      = r_done;
    assign DIV_ZERO  = r_div_zero;
    assign OVF       = r_ovf;

endmodule
